// File: rtl/hs_fifo_slice.sv
// hs_fifo_slice: elastic valid/ready FIFO between a handshake master and slave.
// Define HS_FIFO_LEVEL_EN to expose the registered occupancy on the level port.
module hs_fifo_slice #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 4,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready
`ifdef HS_FIFO_LEVEL_EN
  ,
  output logic [AW:0]       level
`endif
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              push;
  logic              pop;

  // Ready is derived from registered occupancy only, so a full buffer never passes through.
  assign s_ready = reset && (count != FULL);
  assign m_valid = (count != '0);
  assign m_data  = m_valid ? mem[rd_ptr] : '0;

  assign push = s_valid && s_ready;
  assign pop  = m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage carries no reset; an empty buffer masks it from m_data.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

`ifdef HS_FIFO_LEVEL_EN
  assign level = count;
`endif

endmodule

// File: tb/tb_hs_fifo_slice.sv
// Scoreboard bench for hs_fifo_slice: a queue model updated at each rising edge,
// DUT outputs compared against it on the falling edge.
module tb_hs_fifo_slice;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int AW     = $clog2(DEPTH);

  logic              clk;
  logic              reset;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;
`ifdef HS_FIFO_LEVEL_EN
  logic [AW:0]       level;
`endif

  hs_fifo_slice #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_ready (m_ready)
`ifdef HS_FIFO_LEVEL_EN
    ,
    .level   (level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  started = 1'b0;
  int  beats_out = 0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: a plain queue of accepted beats, capacity DEPTH.
  always @(posedge clk) begin
    automatic bit do_push = s_valid && (exp_q.size() != DEPTH);
    automatic bit do_pop  = m_ready && (exp_q.size() != 0);
    if (!reset) begin
      exp_q.delete();
    end else begin
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(s_data);
    end
    started <= 1'b1;
  end

  // Output monitor.
  always @(negedge clk) begin
    if (started) begin
      chk("s_ready", {31'd0, s_ready}, {31'd0, (reset && exp_q.size() != DEPTH)});
      chk("m_valid", {31'd0, m_valid}, {31'd0, (exp_q.size() != 0)});
      if (exp_q.size() != 0) begin
        chk("m_data", m_data, exp_q[0]);
        if (m_ready) beats_out++;
      end else begin
        chk("m_data_empty", m_data, '0);
      end
`ifdef HS_FIFO_LEVEL_EN
      chk("level", {{(DATA_W-AW-1){1'b0}}, level}, DATA_W'(exp_q.size()));
`endif
    end
  end

  task automatic step(input logic rst, input logic v, input logic [DATA_W-1:0] d, input logic rdy);
    reset   = rst;
    s_valid = v;
    s_data  = d;
    m_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;

    // Reset held with a pending beat on the input.
    repeat (3) step(1'b0, 1'b1, 32'hA5A5_A5A5, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1);

    // Single beat, ready held high.
    step(1'b1, 1'b1, 32'h1111_1111, 1'b1);
    repeat (2) step(1'b1, 1'b0, '0, 1'b1);

    // Fill to full under back-pressure, then over-offer.
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, DATA_W'(i), 1'b0);
    repeat (2) step(1'b1, 1'b1, 32'h5, 1'b0);
    // Full with a simultaneous pop: only the pop happens, push accepted next cycle.
    repeat (2) step(1'b1, 1'b1, 32'h5, 1'b1);
    repeat (6) step(1'b1, 1'b0, '0, 1'b1);

    // Streaming through the pointer wrap.
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, DATA_W'(32'h10 + i), 1'b1);
    repeat (2) step(1'b1, 1'b0, '0, 1'b1);

    // Reset with three beats queued.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, DATA_W'(32'hC0 + i), 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    repeat (3) step(1'b1, 1'b0, '0, 1'b1);

    // Randomised traffic including zero payloads and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      automatic logic [DATA_W-1:0] d = ($urandom_range(0, 7) == 0) ? '0 : DATA_W'($urandom);
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 3) != 0),
           d,
           ($urandom_range(0, 2) != 0));
    end
    repeat (8) step(1'b1, 1'b0, '0, 1'b1);

    checks++;
    if (beats_out == 0) begin
      errors++;
      $display("FAIL beats_out: got %0d expected nonzero", beats_out);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
